// File: rtl/alu_pkg.sv
// Shared ALU encodings for the ID->EX issue slice: ALU op codes, main-decoder
// aluop codes and the R-type funct values the decoder recognises.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU decoder: main-decoder aluop plus R-type funct to the
// 3-bit alucontrol, flagging reserved aluop and unknown funct as illegal.
module alu_dec
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        unique case (aluop_t'(aluop))
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   illegal    = 1'b1;
                endcase
            end
            ALUOP_RSVD: illegal = 1'b1;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ID->EX issue stage: decodes and selects ALU operands, then holds them in the
// ID/EX register behind a valid/ready handshake with a one-entry skid buffer.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          aluop,
    input  logic [5:0]          funct,
    input  logic                alusrc,
    input  logic [WIDTH-1:0]    rd1,
    input  logic [WIDTH-1:0]    rd2,
    input  logic [WIDTH-1:0]    signimm,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    srca,
    output logic [WIDTH-1:0]    srcb,
    output logic [2:0]          alucontrol,
    output logic                illegal,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef struct packed {
        logic [WIDTH-1:0] srca;
        logic [WIDTH-1:0] srcb;
        logic [2:0]       ctl;
        logic             ill;
    } op_t;

    logic [2:0] dec_ctl;
    logic       dec_ill;
    op_t        in_op;
    op_t        out_op;
    op_t        skid_op;
    logic       skid_full;
    logic       accept;
    logic       xfer;

    alu_dec u_dec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (dec_ctl),
        .illegal    (dec_ill)
    );

    assign in_op    = '{srca: rd1, srcb: (alusrc ? signimm : rd2), ctl: dec_ctl, ill: dec_ill};
    // in_ready comes from a register only, so EX stalls never ripple into ID.
    assign in_ready = !skid_full;
    // An op presented alongside flush is dropped, so it is not an accept.
    assign accept   = in_valid && in_ready && !flush;
    assign xfer     = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking for all sequential state; control and visible
            // outputs reset, skid payload needs none since skid_full guards it.
            out_valid <= 1'b0;
            skid_full <= 1'b0;
            out_op    <= '{srca: '0, srcb: '0, ctl: ALU_ADD, ill: 1'b0};
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (!out_valid || xfer) begin
            if (skid_full) begin
                out_op    <= skid_op;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) out_op <= in_op;
            end
        end else if (accept) begin
            skid_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && out_valid && !out_ready) skid_op <= in_op;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (accept && dec_ill && (err_count != {ERRCNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end

    assign srca       = out_op.srca;
    assign srcb       = out_op.srcb;
    assign alucontrol = out_op.ctl;
    assign illegal    = out_op.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode, operand select, skid
// behaviour, flush, illegal-op saturation and asynchronous reset.
module tb_alu_issue;

    localparam int WIDTH    = 32;
    localparam int ERRCNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic             alusrc;
    logic [WIDTH-1:0] rd1, rd2, signimm;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] srca, srcb;
    logic [2:0]       alucontrol;
    logic             illegal;
    logic [ERRCNT_W-1:0] err_count;

    int tests  = 0;
    int errors = 0;
    int err_exp = 0;

    always #5 clk = ~clk;

    alu_issue #(.WIDTH(WIDTH), .ERRCNT_W(ERRCNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .aluop      (aluop),
        .funct      (funct),
        .alusrc     (alusrc),
        .rd1        (rd1),
        .rd2        (rd2),
        .signimm    (signimm),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .srca       (srca),
        .srcb       (srcb),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .err_count  (err_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [5:0] fn, input logic src,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        in_valid = 1'b1;
        aluop    = op;
        funct    = fn;
        alusrc   = src;
        rd1      = a;
        rd2      = b;
        signimm  = imm;
    endtask

    // Decode table: aluop, funct, expected alucontrol, expected illegal
    logic [1:0] t_op  [6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10};
    logic [5:0] t_fn  [6] = '{6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b100000, 6'b100000};
    logic [2:0] t_ctl [6] = '{3'b000, 3'b001, 3'b111, 3'b110, 3'b010, 3'b010};
    logic       t_ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        reset = 1'b1; in_valid = 1'b0; aluop = 2'b00; funct = 6'd0; alusrc = 1'b0;
        rd1 = '0; rd2 = '0; signimm = '0; flush = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_ctl", alucontrol, 3'b010);
        check("rst_srca", srca, 0);
        check("rst_srcb", srcb, 0);
        check("rst_err", err_count, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // R-type sub
        @(posedge clk); #1;
        present(2'b10, 6'b100010, 1'b0, 32'd7, 32'd3, 32'd99);
        tick();
        check("sub_valid", out_valid, 1);
        check("sub_ctl", alucontrol, 3'b110);
        check("sub_srca", srca, 7);
        check("sub_srcb", srcb, 3);
        check("sub_ill", illegal, 0);

        // Immediate add
        present(2'b00, 6'b111111, 1'b1, 32'd5, 32'd1, 32'hFFFF_FFFC);
        tick();
        check("addi_srcb", srcb, 32'hFFFF_FFFC);
        check("addi_ctl", alucontrol, 3'b010);
        check("addi_srca", srca, 5);

        // Remaining decodes, pipelined back to back
        for (int i = 0; i < 6; i++) begin
            present(t_op[i], t_fn[i], 1'b0, 32'(i + 100), 32'(i + 200), 32'd0);
            tick();
            if (t_ill[i]) err_exp++;
            check($sformatf("dec%0d_ctl", i), alucontrol, t_ctl[i]);
            check($sformatf("dec%0d_ill", i), illegal, t_ill[i]);
            check($sformatf("dec%0d_srcb", i), srcb, i + 200);
            check($sformatf("dec%0d_err", i), err_count, err_exp);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);

        // Stall: A held, B into skid, C blocked
        out_ready = 1'b0;
        present(2'b00, 6'd0, 1'b0, 32'hA, 32'h1, 32'd0);
        tick();
        check("stallA_valid", out_valid, 1);
        check("stallA_srca", srca, 32'hA);
        check("stallA_ready", in_ready, 1);
        present(2'b01, 6'd0, 1'b0, 32'hB, 32'h2, 32'd0);
        tick();
        check("stallB_srca", srca, 32'hA);
        check("stallB_ctl", alucontrol, 3'b010);
        check("stallB_ready", in_ready, 0);
        present(2'b10, 6'b100100, 1'b0, 32'hC, 32'h3, 32'd0);
        tick();
        check("stallC_srca", srca, 32'hA);
        check("stallC_ready", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("relB_valid", out_valid, 1);
        check("relB_srca", srca, 32'hB);
        check("relB_ctl", alucontrol, 3'b110);
        check("relB_ready", in_ready, 1);
        tick();
        check("relEnd_valid", out_valid, 0);

        // Illegal-op saturation
        present(2'b10, 6'b000000, 1'b0, 32'd1, 32'd2, 32'd0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (err_exp < 255) err_exp++;
            check("sat_ill", illegal, 1);
        end
        check("sat_err", err_count, 255);
        in_valid = 1'b0;
        tick();

        // Flush with skid full
        out_ready = 1'b0;
        present(2'b00, 6'd0, 1'b0, 32'h11, 32'd0, 32'd0);
        tick();
        present(2'b01, 6'd0, 1'b0, 32'h22, 32'd0, 32'd0);
        tick();
        check("fl_skid_ready", in_ready, 0);
        present(2'b00, 6'd0, 1'b0, 32'h33, 32'd0, 32'd0);
        flush = 1'b1;
        tick();
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("fl_after1", out_valid, 0);
        tick();
        check("fl_after2", out_valid, 0);
        check("fl_err_kept", err_count, 255);

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        present(2'b01, 6'd0, 1'b0, 32'h44, 32'h5, 32'd0);
        tick();
        check("ar_pre_valid", out_valid, 1);
        check("ar_pre_ctl", alucontrol, 3'b110);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_ctl", alucontrol, 3'b010);
        check("ar_err", err_count, 0);
        check("ar_srca", srca, 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("ar_post_valid", out_valid, 0);
        check("ar_post_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
